ysyx_22050598_exu_redirect_ctrl: RTL and testbench

//  Sequences every PC redirect out of EXU: ALU branch/jump, ecall/mret and qualified timer IRQ.

---
 rtl/ysyx_22050598_exu_redirect_ctrl.sv | 134 +++++++++++++
 tb/tb_ysyx_22050598_exu_redirect_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050598_exu_redirect_ctrl.sv
// EXU redirect sequencer: arbitrates ALU/ecall/mret/timer-IRQ redirects, runs trap
// entry as a mepc -> mcause CSR write sequence, and hands the target to IFU.
module ysyx_22050598_exu_redirect_ctrl #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned CAUSE_ECALL = 11,
  parameter int unsigned CAUSE_MTI   = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            alu_pc_en_i,
  input  logic [XLEN-1:0] alu_pc_data_i,
  input  logic            csr_ecall_i,
  input  logic            csr_mret_i,
  input  logic            irq_timer_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic            ifu_redir_ready_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  output logic            ex_stall_o,
  output logic            flush_o,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_wr_addr_o,
  output logic [XLEN-1:0] csr_wr_data_o,
  output logic            mstatus_trap_o,
  output logic            mstatus_mret_o
);

  localparam logic [11:0]     CSR_MEPC   = 12'h341;
  localparam logic [11:0]     CSR_MCAUSE = 12'h342;
  localparam logic [XLEN-1:0] CAUSE_IRQ  = {1'b1, (XLEN-1)'(CAUSE_MTI)};
  localparam logic [XLEN-1:0] CAUSE_EC   = XLEN'(CAUSE_ECALL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    W_MEPC   = 2'd1,
    W_MCAUSE = 2'd2,
    REDIR    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] trap_tgt;

  // Direct-mode trap vector: mtvec MODE bits are dropped.
  assign trap_tgt   = {csr_mtvec_i[XLEN-1:2], 2'b00};
  assign ex_stall_o = (state_q != IDLE);

  // State, trap context and latched redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next state and outputs; accept-cycle pulses are gated by rst_n so reset silences everything.
  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    tgt_d          = tgt_q;
    redir_valid_o  = 1'b0;
    redir_pc_o     = '0;
    flush_o        = 1'b0;
    csr_wr_en_o    = 1'b0;
    csr_wr_addr_o  = '0;
    csr_wr_data_o  = '0;
    mstatus_trap_o = 1'b0;
    mstatus_mret_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rst_n && ex_valid_i) begin
          if (irq_timer_i) begin
            cause_d = CAUSE_IRQ;
            epc_d   = ex_pc_i;
            tgt_d   = trap_tgt;
            flush_o = 1'b1;
            state_d = W_MEPC;
          end else if (csr_ecall_i) begin
            cause_d = CAUSE_EC;
            epc_d   = ex_pc_i;
            tgt_d   = trap_tgt;
            flush_o = 1'b1;
            state_d = W_MEPC;
          end else if (csr_mret_i) begin
            tgt_d          = csr_mepc_i;
            mstatus_mret_o = 1'b1;
            flush_o        = 1'b1;
            state_d        = REDIR;
          end else if (alu_pc_en_i) begin
            tgt_d   = {alu_pc_data_i[XLEN-1:1], 1'b0};
            flush_o = 1'b1;
            state_d = REDIR;
          end
        end
      end
      W_MEPC: begin
        csr_wr_en_o   = 1'b1;
        csr_wr_addr_o = CSR_MEPC;
        csr_wr_data_o = epc_q;
        state_d       = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_wr_en_o    = 1'b1;
        csr_wr_addr_o  = CSR_MCAUSE;
        csr_wr_data_o  = cause_q;
        mstatus_trap_o = 1'b1;
        state_d        = REDIR;
      end
      REDIR: begin
        redir_valid_o = 1'b1;
        redir_pc_o    = tgt_q;
        if (ifu_redir_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050598_exu_redirect_ctrl.sv
// Scoreboard bench for the EXU redirect sequencer: directed stimulus pushes expected
// events (with cycle stamps), a negedge monitor pops and compares them.
module tb_ysyx_22050598_exu_redirect_ctrl;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid_i;
  logic [XLEN-1:0] ex_pc_i;
  logic            alu_pc_en_i;
  logic [XLEN-1:0] alu_pc_data_i;
  logic            csr_ecall_i;
  logic            csr_mret_i;
  logic            irq_timer_i;
  logic [XLEN-1:0] csr_mtvec_i;
  logic [XLEN-1:0] csr_mepc_i;
  logic            ifu_redir_ready_i;
  logic            redir_valid_o;
  logic [XLEN-1:0] redir_pc_o;
  logic            ex_stall_o;
  logic            flush_o;
  logic            csr_wr_en_o;
  logic [11:0]     csr_wr_addr_o;
  logic [XLEN-1:0] csr_wr_data_o;
  logic            mstatus_trap_o;
  logic            mstatus_mret_o;

  ysyx_22050598_exu_redirect_ctrl #(.XLEN(XLEN), .CAUSE_ECALL(11), .CAUSE_MTI(7)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid_i        (ex_valid_i),
    .ex_pc_i           (ex_pc_i),
    .alu_pc_en_i       (alu_pc_en_i),
    .alu_pc_data_i     (alu_pc_data_i),
    .csr_ecall_i       (csr_ecall_i),
    .csr_mret_i        (csr_mret_i),
    .irq_timer_i       (irq_timer_i),
    .csr_mtvec_i       (csr_mtvec_i),
    .csr_mepc_i        (csr_mepc_i),
    .ifu_redir_ready_i (ifu_redir_ready_i),
    .redir_valid_o     (redir_valid_o),
    .redir_pc_o        (redir_pc_o),
    .ex_stall_o        (ex_stall_o),
    .flush_o           (flush_o),
    .csr_wr_en_o       (csr_wr_en_o),
    .csr_wr_addr_o     (csr_wr_addr_o),
    .csr_wr_data_o     (csr_wr_data_o),
    .mstatus_trap_o    (mstatus_trap_o),
    .mstatus_mret_o    (mstatus_mret_o)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {EV_FLUSH, EV_MRET, EV_WR, EV_TRAP, EV_REDIR} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    int          cyc;
    logic [11:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input ev_kind_e k, input int c, input logic [11:0] a, input logic [63:0] d);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor side: pop one expectation per observed event.
  task automatic got(input ev_kind_e k, input logic [11:0] a, input logic [63:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected event cycle=%0d addr=%h data=%h, required none", k.name(), cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.cyc == cyc && e.addr == a && e.data == d) passed++;
      else $display("FAIL %s: got cycle=%0d addr=%h data=%h, required %s cycle=%0d addr=%h data=%h",
                    k.name(), cyc, a, d, e.kind.name(), e.cyc, e.addr, e.data);
    end
  endtask

  task automatic hold_chk(input logic [63:0] pc);
    total++;
    if (exp_q.size() != 0 && exp_q[0].kind == EV_REDIR && exp_q[0].data == pc) passed++;
    else $display("FAIL redir_hold: got pc=%h at cycle %0d, required a pending redirect with stable pc", pc, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (flush_o)        got(EV_FLUSH, 12'h0, 64'h0);
      if (mstatus_mret_o) got(EV_MRET, 12'h0, 64'h0);
      if (csr_wr_en_o)    got(EV_WR, csr_wr_addr_o, csr_wr_data_o);
      if (mstatus_trap_o) got(EV_TRAP, 12'h0, 64'h0);
      if (redir_valid_o) begin
        if (ifu_redir_ready_i) got(EV_REDIR, 12'h0, redir_pc_o);
        else hold_chk(redir_pc_o);
      end else if (redir_pc_o != '0) begin
        chk("redir_pc_zero", redir_pc_o, 64'h0);
      end
    end
  end

  task automatic clr();
    ex_valid_i = 1'b0; ex_pc_i = '0; alu_pc_en_i = 1'b0; alu_pc_data_i = '0;
    csr_ecall_i = 1'b0; csr_mret_i = 1'b0; irq_timer_i = 1'b0;
    csr_mtvec_i = '0; csr_mepc_i = '0; ifu_redir_ready_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 64'(redir_valid_o), 64'h0);
    chk({nm, "_pc"}, redir_pc_o, 64'h0);
    chk({nm, "_stall"}, 64'(ex_stall_o), 64'h0);
    chk({nm, "_flush"}, 64'(flush_o), 64'h0);
    chk({nm, "_wr"}, {51'h0, csr_wr_en_o, csr_wr_addr_o}, 64'h0);
    chk({nm, "_wdata"}, csr_wr_data_o, 64'h0);
    chk({nm, "_mst"}, {62'h0, mstatus_trap_o, mstatus_mret_o}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    step();

    // No ex_valid: sources present but nothing accepted.
    ex_pc_i = 64'h8000_0000; alu_pc_en_i = 1'b1; alu_pc_data_i = 64'h8000_0800;
    csr_ecall_i = 1'b1; irq_timer_i = 1'b1; csr_mret_i = 1'b1;
    step(); step();
    clr();
    chk("noval_stall", 64'(ex_stall_o), 64'h0);

    // 1. ALU redirect, bit 0 cleared.
    n = cyc;
    ex_valid_i = 1'b1; alu_pc_en_i = 1'b1; alu_pc_data_i = 64'h8000_0105;
    expect_ev(EV_FLUSH, n, 12'h0, 64'h0);
    expect_ev(EV_REDIR, n + 1, 12'h0, 64'h8000_0104);
    step(); clr();
    chk("alu_stall_n1", 64'(ex_stall_o), 64'h1);
    step();
    chk("alu_stall_n2", 64'(ex_stall_o), 64'h0);
    chk("alu_valid_n2", 64'(redir_valid_o), 64'h0);

    // 2. ecall trap entry.
    n = cyc;
    ex_valid_i = 1'b1; csr_ecall_i = 1'b1; ex_pc_i = 64'h8000_0010; csr_mtvec_i = 64'h8000_1001;
    expect_ev(EV_FLUSH, n, 12'h0, 64'h0);
    expect_ev(EV_WR, n + 1, 12'h341, 64'h8000_0010);
    expect_ev(EV_WR, n + 2, 12'h342, 64'd11);
    expect_ev(EV_TRAP, n + 2, 12'h0, 64'h0);
    expect_ev(EV_REDIR, n + 3, 12'h0, 64'h8000_1000);
    step(); clr();
    chk("ecall_stall", 64'(ex_stall_o), 64'h1);
    repeat (3) step();
    chk("ecall_idle", 64'(ex_stall_o), 64'h0);

    // 3. IRQ beats ecall and ALU.
    n = cyc;
    ex_valid_i = 1'b1; irq_timer_i = 1'b1; csr_ecall_i = 1'b1; alu_pc_en_i = 1'b1;
    alu_pc_data_i = 64'h8000_0900; ex_pc_i = 64'h8000_0020; csr_mtvec_i = 64'h8000_2003;
    expect_ev(EV_FLUSH, n, 12'h0, 64'h0);
    expect_ev(EV_WR, n + 1, 12'h341, 64'h8000_0020);
    expect_ev(EV_WR, n + 2, 12'h342, 64'h8000_0000_0000_0007);
    expect_ev(EV_TRAP, n + 2, 12'h0, 64'h0);
    expect_ev(EV_REDIR, n + 3, 12'h0, 64'h8000_2000);
    step(); clr();
    repeat (3) step();
    chk("irq_idle", 64'(ex_stall_o), 64'h0);

    // 4. mret with IFU back-pressure for 3 cycles.
    n = cyc;
    ex_valid_i = 1'b1; csr_mret_i = 1'b1; csr_mepc_i = 64'h8000_0014; ifu_redir_ready_i = 1'b0;
    expect_ev(EV_FLUSH, n, 12'h0, 64'h0);
    expect_ev(EV_MRET, n, 12'h0, 64'h0);
    expect_ev(EV_REDIR, n + 4, 12'h0, 64'h8000_0014);
    for (int i = 1; i <= 4; i++) begin
      step(); clr();
      ifu_redir_ready_i = (i == 4);
      chk("mret_stall", 64'(ex_stall_o), 64'h1);
    end
    step(); clr();
    chk("mret_idle", 64'(ex_stall_o), 64'h0);

    // 5. Reset during W_MCAUSE drops the rest of the trap.
    n = cyc;
    ex_valid_i = 1'b1; csr_ecall_i = 1'b1; ex_pc_i = 64'h8000_0030; csr_mtvec_i = 64'h8000_3000;
    expect_ev(EV_FLUSH, n, 12'h0, 64'h0);
    expect_ev(EV_WR, n + 1, 12'h341, 64'h8000_0030);
    step(); clr();
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    chk("rst_after_stall", 64'(ex_stall_o), 64'h0);
    chk("rst_after_valid", 64'(redir_valid_o), 64'h0);

    // 6. Inputs toggled while in REDIR are ignored.
    n = cyc;
    ex_valid_i = 1'b1; alu_pc_en_i = 1'b1; alu_pc_data_i = 64'h8000_0201; ifu_redir_ready_i = 1'b0;
    expect_ev(EV_FLUSH, n, 12'h0, 64'h0);
    expect_ev(EV_REDIR, n + 4, 12'h0, 64'h8000_0200);
    for (int i = 1; i <= 4; i++) begin
      step();
      ifu_redir_ready_i = (i == 4);
      ex_valid_i = 1'b1; irq_timer_i = 1'(i % 2); csr_ecall_i = 1'b1; csr_mret_i = 1'b1;
      alu_pc_en_i = 1'b1; alu_pc_data_i = 64'hdead_0000 + 64'(i);
      ex_pc_i = 64'hbeef_0000 + 64'(i); csr_mtvec_i = 64'h9000_0000; csr_mepc_i = 64'h9100_0000;
      chk("tog_stall", 64'(ex_stall_o), 64'h1);
    end
    step(); clr();
    chk("tog_idle", 64'(ex_stall_o), 64'h0);

    // 7. Back-to-back: no accept in handshake cycle, accept right after.
    n = cyc;
    ex_valid_i = 1'b1; alu_pc_en_i = 1'b1; alu_pc_data_i = 64'h8000_0300;
    expect_ev(EV_FLUSH, n, 12'h0, 64'h0);
    expect_ev(EV_REDIR, n + 1, 12'h0, 64'h8000_0300);
    step();
    alu_pc_data_i = 64'h8000_0400;
    step();
    alu_pc_data_i = 64'h8000_0500;
    expect_ev(EV_FLUSH, n + 2, 12'h0, 64'h0);
    expect_ev(EV_REDIR, n + 3, 12'h0, 64'h8000_0500);
    step(); clr();
    step();
    chk("b2b_idle", 64'(ex_stall_o), 64'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
